// File: rtl/sprite_pkg.sv
// sprite_pkg: word layout of the shared sprite-attribute RAM, motion FSM
// state encoding and small helpers shared by the renderer, CPU map and
// the motion engine.
package sprite_pkg;

  localparam int NB_DEFAULT       = 5;
  localparam int WORDS_PER_SPRITE = 2;

  localparam int POS_W = 8;
  localparam int VEL_W = 4;

  // word0 = {Y, X}
  localparam int X_LSB = 0;
  localparam int Y_LSB = 8;

  // word1 = {dy, dx, attr}
  localparam int ATTR_LSB = 0;
  localparam int DX_LSB   = 8;
  localparam int DY_LSB   = 12;

  typedef enum logic [3:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6,
    DONE
  } motion_state_t;

  // Two's-complement negate of a 4-bit velocity; -(-8) saturates to +7
  function automatic logic [VEL_W-1:0] negate_vel(input logic [VEL_W-1:0] vel);
    logic [VEL_W-1:0] result;
    if (vel == 4'b1000) result = 4'b0111;
    else                result = ~vel + 4'd1;
    return result;
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: combinational one-axis position/velocity update.
// Out-of-range moves bounce (position kept, velocity reversed) unless
// SPRITE_MOTION_WRAP_EN is defined, in which case the position wraps
// around the legal range and the velocity is kept.
module sprite_axis_step
  import sprite_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [VEL_W-1:0] vel,
  input  logic [POS_W-1:0] axis_min,
  input  logic [POS_W-1:0] axis_max,
  output logic [POS_W-1:0] new_pos,
  output logic [VEL_W-1:0] new_vel,
  output logic             flipped
);

  logic signed [9:0] sum;
  logic signed [9:0] lo;
  logic signed [9:0] hi;
  logic              below;
  logic              above;

  // Candidate position in a signed range wide enough for 0..255 plus -8..+7
  always_comb begin
    sum   = $signed({2'b00, pos}) + $signed({{(10-VEL_W){vel[VEL_W-1]}}, vel});
    lo    = $signed({2'b00, axis_min});
    hi    = $signed({2'b00, axis_max});
    below = (sum < lo);
    above = (sum > hi);
  end

  // In-range moves are taken as-is; out-of-range handling depends on the build
  always_comb begin
    new_pos = sum[POS_W-1:0];
    new_vel = vel;
    flipped = 1'b0;
`ifdef SPRITE_MOTION_WRAP_EN
    if (above) begin
      new_pos = axis_min + (sum[POS_W-1:0] - axis_max - 8'd1);
    end else if (below) begin
      new_pos = axis_max - (axis_min - sum[POS_W-1:0] - 8'd1);
    end
`else
    if (above || below) begin
      new_pos = pos;
      new_vel = negate_vel(vel);
      flipped = (vel != '0);
    end
`endif
  end

endmodule

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: once per frame, during vertical blank, walks the
// sprite-attribute RAM, adds each sprite's velocity to its position and
// bounces it off the screen limits (or wraps, when SPRITE_MOTION_WRAP_EN
// is defined). Each sprite takes 7 cycles: read word1, read word0,
// compute, write word0, write word1.
module sprite_motion_engine
  import sprite_pkg::*;
#(
  parameter int NB         = NB_DEFAULT,
  parameter int START_LINE = 256,
  parameter int XMIN       = 0,
  parameter int XMAX       = 240,
  parameter int YMIN       = 0,
  parameter int YMAX       = 224
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [8:0]                              hpos,
  input  logic [8:0]                              vpos,
  input  logic                                    enable,
  input  logic                                    ram_busy,
  output logic [NB+$clog2(WORDS_PER_SPRITE)-1:0]  ram_addr,
  input  logic [15:0]                             ram_din,
  output logic [15:0]                             ram_dout,
  output logic                                    ram_we,
  output logic                                    active,
  output logic                                    done
);

  localparam logic WORD_POS = 1'b0;
  localparam logic WORD_VEL = 1'b1;

  motion_state_t     state;
  logic [NB-1:0]     idx;
  logic [15:0]       word0_q;
  logic [15:0]       word1_q;
  logic              we_q;
  logic              start_hit;

  logic [POS_W-1:0]  x_next;
  logic [POS_W-1:0]  y_next;
  logic [VEL_W-1:0]  dx_next;
  logic [VEL_W-1:0]  dy_next;
  logic              x_flipped;
  logic              y_flipped;
  logic [15:0]       new_word0;
  logic [15:0]       new_word1;

  assign start_hit = (vpos == 9'(START_LINE)) && (hpos == '0) && enable;

  // The write strobe is gated live by ram_busy so the renderer's RAM window is never written into
  assign ram_we = we_q & ~ram_busy;

  sprite_axis_step u_step_x (
    .pos      (word0_q[X_LSB +: POS_W]),
    .vel      (word1_q[DX_LSB +: VEL_W]),
    .axis_min (POS_W'(XMIN)),
    .axis_max (POS_W'(XMAX)),
    .new_pos  (x_next),
    .new_vel  (dx_next),
    .flipped  (x_flipped)
  );

  sprite_axis_step u_step_y (
    .pos      (word0_q[Y_LSB +: POS_W]),
    .vel      (word1_q[DY_LSB +: VEL_W]),
    .axis_min (POS_W'(YMIN)),
    .axis_max (POS_W'(YMAX)),
    .new_pos  (y_next),
    .new_vel  (dy_next),
    .flipped  (y_flipped)
  );

  // Assemble write-back words; velocity fields are replaced only when that axis reversed
  always_comb begin
    new_word0 = '0;
    new_word0[X_LSB +: POS_W] = x_next;
    new_word0[Y_LSB +: POS_W] = y_next;
    new_word1 = '0;
    new_word1[ATTR_LSB +: 8]   = word1_q[ATTR_LSB +: 8];
    new_word1[DX_LSB +: VEL_W] = x_flipped ? dx_next : word1_q[DX_LSB +: VEL_W];
    new_word1[DY_LSB +: VEL_W] = y_flipped ? dy_next : word1_q[DY_LSB +: VEL_W];
  end

  // Pass sequencer with registered RAM-side outputs; busy before the writes restarts the sprite read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      ram_addr <= '0;
      ram_dout <= '0;
      we_q     <= 1'b0;
      active   <= 1'b0;
      done     <= 1'b0;
      word0_q  <= '0;
      word1_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_hit) begin
            state    <= S0;
            idx      <= '0;
            active   <= 1'b1;
            ram_addr <= {{NB{1'b0}}, WORD_VEL};
          end
        end
        S0: begin
          if (!ram_busy) state <= S1;
        end
        S1, S2, S3, S4: begin
          if (ram_busy) begin
            state    <= S0;
            ram_addr <= {idx, WORD_VEL};
          end else if (state == S1) begin
            word1_q  <= ram_din;
            ram_addr <= {idx, WORD_POS};
            state    <= S2;
          end else if (state == S2) begin
            state <= S3;
          end else if (state == S3) begin
            word0_q <= ram_din;
            state   <= S4;
          end else begin
            ram_addr <= {idx, WORD_POS};
            ram_dout <= new_word0;
            we_q     <= 1'b1;
            state    <= S5;
          end
        end
        S5: begin
          if (!ram_busy) begin
            ram_addr <= {idx, WORD_VEL};
            ram_dout <= new_word1;
            state    <= S6;
          end
        end
        S6: begin
          if (!ram_busy) begin
            we_q <= 1'b0;
            if (idx == {NB{1'b1}}) begin
              state    <= DONE;
              active   <= 1'b0;
              done     <= 1'b1;
              ram_addr <= '0;
              ram_dout <= '0;
            end else begin
              idx      <= idx + NB'(1);
              ram_addr <= {idx + NB'(1), WORD_VEL};
              state    <= S0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_motion_engine.md
Name: sprite_motion_engine

Overview:
- Upstream stage of the scanline sprite renderer. Once per frame, during vertical blank, it walks the shared sprite-attribute RAM.
- For each sprite it reads position and velocity, adds the velocity, bounces off the screen limits, and writes the results back.
- It runs before the renderer's line-260 RAM load, so every frame the renderer sees updated positions without CPU involvement.

Parameters:
- NB, 5: 2^NB sprites; each sprite uses 2 RAM words.
- START_LINE, 256: vpos on which the frame pass starts.
- XMIN, 0: lowest legal X.
- XMAX, 240: highest legal X.
- YMIN, 0: lowest legal Y.
- YMAX, 224: highest legal Y.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- hpos  in  9  horizontal position from hvsync_generator.
- vpos  in  9  vertical position from hvsync_generator.
- enable  in  1  sampled at pass start; 0 skips this frame.
- ram_busy  in  1  renderer owns RAM; engine must not write.
- ram_addr  out  NB+1  word address: {sprite, word}.
- ram_din  in  16  read data from RAM_sync.
- ram_dout  out  16  write data.
- ram_we  out  1  write strobe.
- active  out  1  high while a pass is running.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- RAM word layout:
  - Word0 = {Y[15:8], X[7:0]}.
  - Word1 = {dy[15:12], dx[11:8], attr[7:0]}; dx and dy are signed 4-bit.
- Reset (reset=0, async): all outputs 0; FSM IDLE; sprite index 0.
- RAM timing: RAM_sync is synchronous-read. An address driven from a register at edge t gives data that is captured at edge t+2.
- Start: in IDLE, sampling vpos==START_LINE && hpos==0 && enable==1 moves the FSM to S0 with sprite index 0 and sets active=1.
  - The start condition is ignored while a pass is active.
  - enable==0 at the start sample: no pass this frame.
- Per-sprite states, 7 cycles each:
  - S0: addr={i,1}.
  - S1: wait.
  - S2: latch word1; addr={i,0}.
  - S3: wait.
  - S4: latch word0; compute.
  - S5: addr={i,0}, dout=new word0, we=1.
  - S6: addr={i,1}, dout=new word1 (attr unchanged), we=1.
  - After S6: i==N-1 goes to DONE, otherwise i+1 goes to S0.
- DONE (one cycle): done=1, active=0, then IDLE. done is asserted 7N+1 cycles after the start sample (225 for NB=5).
- ram_we is 1 only in S5 and S6.
- Per-axis arithmetic, shown for X (Y is identical with YMIN/YMAX):
  - n = {1'b0,X} + sign-extended dx, computed in 10-bit signed.
  - If XMIN <= n <= XMAX: X'=n, dx'=dx.
  - Otherwise: X'=X (unchanged) and dx'=-dx. -(-8) saturates to +7.
  - dx=0 never bounces.
  - Out-of-range X already present in RAM: the same rule applies and no clamp is performed.
- ram_busy handling:
  - Seen high in S0..S4: ram_we=0 and the sprite restarts at S0 on the first cycle ram_busy is low. Nothing has been written yet, so there is no double-apply.
  - Seen high in S5 or S6: hold the state with ram_we=0, then perform that write once ram_busy is low.
- Reset mid-pass: immediate IDLE. A sprite may be left with word0 updated and word1 not; this is accepted, and the next pass proceeds normally.
- Wrap: the sprite index is NB bits; there is no wrap past N-1.

Optional Feature:
- Macro: SPRITE_MOTION_WRAP_EN.
- Defined: an out-of-range axis wraps instead of bouncing.
  - n > MAX gives X' = MIN + (n - MAX - 1).
  - n < MIN gives X' = MAX - (MIN - n - 1).
  - Velocity is unchanged, so word1 is rewritten with identical data.
- Undefined: bounce behaviour as above.

Decomposition:
- Shared package sprite_pkg:
  - Word-layout field offsets: X, Y, DX, DY, ATTR.
  - Per-sprite word count (2).
  - FSM state enum: IDLE, S0..S6, DONE.
  - Default NB.
  - Shared by the renderer, the CPU map and this block.
- One sub-module, sprite_axis_step, instantiated twice (X and Y).
  - Inputs: pos[7:0], vel[3:0], min, max.
  - Outputs: new pos, new vel, flipped.
  - Combinational; contains the bounce and wrap logic.

Test Plan:
- Sprite 0: X=10, Y=20, dx=+3, dy=-2, attr=0x5A, enable=1 -> after done, word0=0x120D and word1 = 0xE35A (dy=-2 is 4'hE, dx=+3 is 4'h3), attr unchanged.
- X=239, dx=+3 -> X stays 239, dx=-3 (word1[11:8]=4'hD). Also X=5, dx=-8 -> X=5, dx=+7.
- NB=5, full pass -> active for 7*32 cycles; done pulses exactly 225 cycles after the start sample; no start on the next START_LINE while enable=0.
- ram_busy pulsed in S3 of sprite 4 -> sprite 4 is re-read from S0 and its position is updated exactly once.
- ram_busy held through S5 of sprite 4 -> no we while busy; the write completes after release with the correct data.
- reset low in S6 of sprite 7 -> outputs 0 immediately. Sprites 0..6 are updated; sprite 7 word0 is updated, word1 is not; the next frame pass runs cleanly.
- With SPRITE_MOTION_WRAP_EN, XMAX=240: X=239, dx=+3 -> X=1, dx=+3.
